// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Produces four packed BCD digits; dat_out only updates when a conversion completes.
module bin2bcd_seq #(
  parameter int N_BITS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_BITS-1:0] dat_in,
  output logic              busy,
  output logic              done,
  output logic [15:0]       dat_out
);

  localparam int W  = 16 + N_BITS;
  localparam int CW = $clog2(N_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [W-1:0]    work, work_nxt, shifted;
  logic [15:0]     bcd_adj, out_nxt;

  // Upper 16 bits of work hold the BCD digits, lower N_BITS the remaining binary.
  always_comb begin
    bcd_adj = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (work[N_BITS + 4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = work[N_BITS + 4*i +: 4] + 4'd3;
      else
        bcd_adj[4*i +: 4] = work[N_BITS + 4*i +: 4];
    end
    shifted = W'({bcd_adj, work[N_BITS-1:0], 1'b0});
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    work_nxt  = work;
    out_nxt   = dat_out;
    unique case (state)
      IDLE: begin
        if (start) begin
          work_nxt  = {16'h0000, dat_in};
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        work_nxt = shifted;
        cnt_nxt  = cnt + 1'b1;
        // The final shift lands directly in dat_out on the same edge.
        if (cnt == LAST) begin
          out_nxt   = shifted[W-1 -: 16];
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      work    <= '0;
      dat_out <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      work    <= work_nxt;
      dat_out <= out_nxt;
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: random and directed conversions compared
// against a decimal-digit arithmetic model.
module tb_bin2bcd_seq;
  localparam int N = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  dat_in;
  logic          busy;
  logic          done;
  logic [15:0]   dat_out;

  int checks   = 0;
  int failures = 0;

  bin2bcd_seq #(.N_BITS(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dat_in  (dat_in),
    .busy    (busy),
    .done    (done),
    .dat_out (dat_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int unsigned v);
    to_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic bit valid_bcd(input logic [15:0] x);
    valid_bcd = (x[3:0] <= 4'd9) && (x[7:4] <= 4'd9) && (x[11:8] <= 4'd9) && (x[15:12] <= 4'd9);
  endfunction

  // Runs one conversion from a negedge in IDLE; scrambles dat_in after acceptance.
  task automatic convert(input logic [N-1:0] v, output logic [15:0] res, output int n_done,
                         output int n_busy, output int done_idx, output bit early);
    logic [15:0] prev;
    prev = dat_out; res = dat_out;
    n_done = 0; n_busy = 0; done_idx = -1; early = 1'b0;
    start = 1'b1; dat_in = v;
    for (int i = 0; i < N + 4; i++) begin
      @(posedge clk); #1;
      start  = 1'b0;
      dat_in = N'($urandom);
      @(negedge clk);
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (done_idx < 0) done_idx = i;
        res = dat_out;
      end
      if (done_idx < 0 && dat_out !== prev) early = 1'b1;
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({busy, done, dat_out} !== 18'h0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b dat_out=%h, want 0 0 0000", busy, done, dat_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_conv(input string name, input int unsigned v);
    logic [15:0] res; int nd, nb, di; bit early;
    convert(N'(v), res, nd, nb, di, early);
    checks++;
    if (res !== to_bcd(v)) begin
      failures++; $display("FAIL %s_value(%0d): dat_out=%h want %h", name, v, res, to_bcd(v));
    end
    checks++;
    if (nd != 1 || di != N) begin
      failures++; $display("FAIL %s_done(%0d): pulses=%0d at idx=%0d, want 1 at %0d", name, v, nd, di, N);
    end
    checks++;
    if (nb != N) begin
      failures++; $display("FAIL %s_busy(%0d): busy cycles=%0d want %0d", name, v, nb, N);
    end
    checks++;
    if (early || !valid_bcd(res)) begin
      failures++; $display("FAIL %s_hold(%0d): early_change=%b dat_out=%h want stable, all nibbles<=9", name, v, early, res);
    end
  endtask

  task automatic test_zero;
    check_conv("zero", 0);
  endtask

  task automatic test_vectors;
    int unsigned vals[3] = '{1023, 599, 9};
    foreach (vals[i]) check_conv("directed", vals[i]);
    for (int i = 0; i < 25; i++) check_conv("random", $urandom_range(1023, 0));
  endtask

  task automatic test_ignore_start;
    int nd, nb, di;
    logic [15:0] res;
    nd = 0; nb = 0; di = -1; res = dat_out;
    start = 1'b1; dat_in = N'(512);
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      if (i == 0) start = 1'b0;
      if (i == 2) begin start = 1'b1; dat_in = N'(77); end
      if (i == 4) start = 1'b0;
      @(negedge clk);
      if (busy) nb++;
      if (done) begin nd++; if (di < 0) di = i; res = dat_out; end
    end
    checks++;
    if (res !== 16'h0512) begin
      failures++; $display("FAIL ignore_value: dat_out=%h want 0512", res);
    end
    checks++;
    if (nd != 1 || di != N || nb != N) begin
      failures++; $display("FAIL ignore_pulses: done=%0d at idx=%0d busy=%0d, want 1 at %0d busy %0d", nd, di, nb, N, N);
    end
  endtask

  task automatic test_back_to_back;
    int unsigned v, since, cyc;
    v = 0; since = 0; cyc = 0;
    start = 1'b1; dat_in = '0;
    while (v < 1024 && cyc < 1024 * 12 + 100) begin
      @(negedge clk);
      cyc++; since++;
      if (done) begin
        checks++;
        if (dat_out !== to_bcd(v) || !valid_bcd(dat_out)) begin
          failures++; $display("FAIL b2b_value(%0d): dat_out=%h want %h", v, dat_out, to_bcd(v));
        end
        if (v > 0) begin
          checks++;
          if (since != N + 2) begin
            failures++; $display("FAIL b2b_period(%0d): period=%0d want %0d", v, since, N + 2);
          end
        end
        since = 0;
        v++;
        dat_in = N'(v);
      end
    end
    start = 1'b0;
    checks++;
    if (v < 1024) begin
      failures++; $display("FAIL b2b_timeout: results=%0d want 1024", v);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_async_reset;
    bit was_busy;
    int nd;
    start = 1'b1; dat_in = N'(900);
    @(posedge clk); #1; start = 1'b0;
    repeat (6) @(negedge clk);
    was_busy = busy;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (!was_busy || {busy, done, dat_out} !== 18'h0) begin
      failures++;
      $display("FAIL async_reset: prior busy=%b now busy=%b done=%b dat_out=%h, want 1 then 0 0 0000",
               was_busy, busy, done, dat_out);
    end
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy || dat_out !== 16'h0) nd++;
    end
    checks++;
    if (nd != 0) begin
      failures++; $display("FAIL abort_quiet: active cycles=%0d want 0", nd);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_conv("after_reset", 900);
  endtask

  task automatic test_excess3;
    logic [15:0] res; int nd, nb, di; bit early;
    logic [15:0] xs3;
    convert(N'(1023), res, nd, nb, di, early);
    for (int unsigned i = 0; i < 4; i++) xs3[4*i +: 4] = res[4*i +: 4] + 4'd3;
    checks++;
    if (xs3 !== 16'h4356) begin
      failures++; $display("FAIL excess3: digits=%h want 4356", xs3);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dat_in = '0;
    test_reset();
    test_zero();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    test_excess3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
